// File: rtl/gaussian_blur.sv
// gaussian_blur: streaming 3x3 Gaussian smoothing between FWFT FIFOs, border pixels forced to 0
module gaussian_blur #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 32,
    parameter int DWIDTH     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] in_dout,
    input  logic              in_empty,
    output logic              in_rd_en,
    output logic [DWIDTH-1:0] out_din,
    input  logic              out_full,
    output logic              out_wr_en
);
    localparam int W  = IMG_WIDTH;
    localparam int H  = IMG_HEIGHT;
    localparam int N  = W * H;
    localparam int SL = 2 * W + 2;
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(W);
    localparam int HW = $clog2(H);
    localparam int FW = $clog2(W + 1);
    localparam int SW = DWIDTH + 4;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t            state, state_next;
    logic [DWIDTH-1:0] sr [SL];
    logic [RW-1:0]     rd_count;
    logic [FW-1:0]     flush_count;
    logic [CW-1:0]     col;
    logic [HW-1:0]     row;
    logic [SW-1:0]     sum;
    logic [DWIDTH-1:0] blur;
    logic              interior;

    // sr[k] holds the pixel k+1 behind in_dout, so the center sits at sr[W]
    always_comb begin
        sum = SW'(in_dout) + SW'(sr[1]) + SW'(sr[2*W-1]) + SW'(sr[2*W+1])
            + ((SW'(sr[0]) + SW'(sr[W-1]) + SW'(sr[W+1]) + SW'(sr[2*W])) << 1)
            + (SW'(sr[W]) << 2);
        blur = DWIDTH'(sum >> 4);
        interior = row != '0 && row != HW'(H - 1) && col != '0 && col != CW'(W - 1);
    end

    always_comb begin
        state_next = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        out_din    = '0;
        case (state)
            FILL: begin
                in_rd_en = !in_empty;
                if (in_rd_en && rd_count == RW'(W)) state_next = RUN;
            end
            RUN: begin
                in_rd_en  = !in_empty && !out_full;
                out_wr_en = in_rd_en;
                out_din   = interior ? blur : '0;
                if (in_rd_en && rd_count == RW'(N - 1)) state_next = FLUSH;
            end
            FLUSH: begin
                out_wr_en = !out_full;
                if (out_wr_en && flush_count == FW'(W)) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
        if (reset) begin
            in_rd_en   = 1'b0;
            out_wr_en  = 1'b0;
            out_din    = '0;
            state_next = FILL;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || (state == FLUSH && state_next == FILL)) begin
            state       <= FILL;
            rd_count    <= '0;
            flush_count <= '0;
            row         <= '0;
            col         <= '0;
        end else begin
            state <= state_next;
            if (in_rd_en) rd_count <= rd_count + 1'b1;
            if (state == RUN && out_wr_en) begin
                col <= (col == CW'(W - 1)) ? '0 : col + 1'b1;
                if (col == CW'(W - 1)) row <= (row == HW'(H - 1)) ? '0 : row + 1'b1;
            end
            if (state == FLUSH && out_wr_en) flush_count <= flush_count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (in_rd_en) begin
            sr[0] <= in_dout;
            for (int i = 1; i < SL; i++) sr[i] <= sr[i-1];
        end
    end
endmodule

// File: tb/tb_gaussian_blur.sv
// tb_gaussian_blur: randomized and directed frames scored against a kernel-level model of the blur
module tb_gaussian_blur;
    localparam int W = 64;
    localparam int H = 32;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_dout = '0;
    logic       in_empty = 1'b1;
    logic       out_full = 1'b0;
    logic       in_rd_en, out_wr_en;
    logic [7:0] out_din;

    always #5 clock = ~clock;

    gaussian_blur #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en)
    );

    int checks = 0, errors = 0;
    int img [H][W];
    int src[$];
    int exp_q[$];
    int got [2*N];
    int pops, pushes, first_push_pop, ncyc, stall_at, stall_left, full_pct;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int model(input int r, input int c);
        int s = 0;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += img[r+dr][c+dc] * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
        return s / 16;
    endfunction

    task automatic load_frame();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) src.push_back(img[r][c]);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) exp_q.push_back(model(r, c));
    endtask

    task automatic fill_img(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = mode < 0 ? int'($urandom_range(255)) : mode == 1000 ? c * 4 : mode;
    endtask

    task automatic start_test();
        pops = 0; pushes = 0; first_push_pop = -1;
        stall_at = -1; stall_left = 0; full_pct = 0;
        src.delete(); exp_q.delete();
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge
    task automatic cycle(input int empty_pct);
        bit full;
        @(negedge clock);
        full = stall_left > 0 || (full_pct > 0 && $urandom_range(99) < full_pct);
        in_empty = src.size() == 0 || (stall_left == 0 && $urandom_range(99) < empty_pct);
        in_dout = src.size() != 0 ? 8'(src[0]) : 8'd0;
        out_full = full;
        #1;
        if (stall_left > 0) begin
            chk("stall_pop", int'(in_rd_en), 0);
            chk("stall_push", int'(out_wr_en), 0);
            stall_left--;
        end else if (stall_at >= 0 && pops == stall_at) begin
            stall_left = 7;
            stall_at = -1;
        end
        if (in_rd_en) begin
            chk("pop_nonempty", int'(in_empty), 0);
            if (src.size() != 0) void'(src.pop_front());
            pops++;
        end
        if (out_wr_en) begin
            chk("push_notfull", int'(out_full), 0);
            if (first_push_pop < 0) first_push_pop = pops;
            if (exp_q.size() == 0) chk("extra_push", int'(out_wr_en), 0);
            else chk("pixel", int'(out_din), exp_q.pop_front());
            if (pushes < 2 * N) got[pushes] = int'(out_din);
            pushes++;
        end
        ncyc++;
    endtask

    task automatic run(input int stop_pops, input int stop_pushes, input int empty_pct);
        ncyc = 0;
        while (pops < stop_pops && pushes < stop_pushes && ncyc < 30000) cycle(empty_pct);
        if (ncyc >= 30000) chk("timeout", ncyc, 0);
    endtask

    task automatic drain(input int target);
        repeat (5) cycle(0);
        chk("push_count", pushes, target);
        chk("leftover_expected", exp_q.size(), 0);
        chk("leftover_input", src.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_empty = 1'b0; out_full = 1'b0; in_dout = 8'd55;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("reset_rd_en", int'(in_rd_en), 0);
        chk("reset_wr_en", int'(out_wr_en), 0);
        chk("reset_din", int'(out_din), 0);
        @(negedge clock);
        reset = 1'b0; in_empty = 1'b1;
    endtask

    initial begin
        start_test();
        do_reset();

        // constant frame, no stalls
        start_test(); fill_img(100); load_frame();
        run(1 << 30, N, 0);
        chk("const_cycles", ncyc, N + W + 1);
        chk("first_push_pop", first_push_pop, W + 2);
        chk("const_interior_tl", got[W + 1], 100);
        chk("const_interior_br", got[30 * W + 62], 100);
        chk("const_corner", got[0], 0);
        chk("const_right_edge", got[5 * W + 63], 0);
        chk("const_last", got[N - 1], 0);
        drain(N);

        // impulse response
        start_test(); fill_img(0); img[10][10] = 160; load_frame();
        run(1 << 30, N, 0);
        chk("imp_center", got[10 * W + 10], 40);
        chk("imp_up", got[9 * W + 10], 20);
        chk("imp_right", got[10 * W + 11], 20);
        chk("imp_diag", got[11 * W + 11], 10);
        chk("imp_far", got[12 * W + 10], 0);
        drain(N);

        // saturation: 16*255 >> 4
        start_test(); fill_img(255); load_frame();
        run(1 << 30, N, 0);
        chk("sat_interior", got[5 * W + 5], 255);
        chk("sat_border", got[W], 0);
        drain(N);

        // random pixels, 30% empty, 7-cycle full hold mid-RUN
        start_test(); fill_img(-1); load_frame(); stall_at = 300;
        run(1 << 30, N, 30);
        chk("stall_taken", stall_at, -1);
        drain(N);

        // mid-frame reset, then a clean constant frame
        start_test(); fill_img(100); load_frame();
        run(500, 1 << 30, 0);
        do_reset();
        start_test(); load_frame();
        run(1 << 30, N, 0);
        chk("rst_first_push_pop", first_push_pop, W + 2);
        chk("rst_interior", got[2 * W + 2], 100);
        drain(N);

        // back-to-back ramp then constant
        start_test(); fill_img(1000); load_frame(); fill_img(100); load_frame();
        run(1 << 30, 2 * N, 0);
        chk("b2b_cycles", ncyc, 2 * (N + W + 1));
        chk("b2b_ramp", got[2 * W + 5], 20);
        chk("b2b_const", got[N + 3 * W + 7], 100);
        chk("b2b_const_border", got[N], 0);
        drain(2 * N);

        // random pixels with random empty and full on both sides
        start_test(); fill_img(-1); load_frame(); full_pct = 25;
        run(1 << 30, N, 20);
        full_pct = 0;
        drain(N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
